// File: rtl/nios_pio_edge_in_pkg.sv
// nios_pio_edge_in shared definitions.
// Register addresses and edge capture modes.
package nios_pio_pkg;

    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_RSVD = 2'd1;
    localparam logic [1:0] ADDR_MASK = 2'd2;
    localparam logic [1:0] ADDR_EDGE = 2'd3;

    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

    // Counter width able to hold the priming limit stages+1.
    function automatic int prime_width(input int stages);
        return $clog2(stages + 2);
    endfunction

endpackage

// File: rtl/nios_pio_edge_in_if.sv
// Avalon-MM slave bus bundle for nios_pio_edge_in.
// The master drives address/strobes, the slave returns readdata.
interface nios_pio_edge_in_if;

    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );

endinterface

// File: rtl/nios_pio_edge_in_sync_edge.sv
// Input synchronizer, prev register, prime counter and edge terms.
// Edges are suppressed until the pipeline has refilled after reset.
module pio_sync_edge
    import nios_pio_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_TYPE   = EDGE_RISE
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] sync,
    output logic [WIDTH-1:0] edge_vec
);

    localparam int CW = prime_width(SYNC_STAGES);
    localparam logic [CW-1:0] PRIMED = CW'(SYNC_STAGES + 1);

    logic [WIDTH-1:0] stage_q [SYNC_STAGES];
    logic [WIDTH-1:0] prev_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] term;
    logic             primed;

    assign sync   = stage_q[SYNC_STAGES-1];
    assign primed = (cnt_q == PRIMED);

    // Shift the input through the sync chain; prev trails sync by one clock.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                stage_q[i] <= '0;
            end
            prev_q <= '0;
        end else begin
            stage_q[0] <= in_port;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
            prev_q <= sync;
        end
    end

    // Prime counter saturates once sync and prev both hold real input data.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (!primed) begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    // Select the edge polarity for this instance.
    always_comb begin
        term = '0;
        case (EDGE_TYPE)
            EDGE_RISE: term = sync & ~prev_q;
            EDGE_FALL: term = ~sync & prev_q;
            EDGE_ANY:  term = sync ^ prev_q;
            default:   term = sync ^ prev_q;
        endcase
    end

    assign edge_vec = primed ? term : '0;

endmodule

// File: rtl/nios_pio_edge_in.sv
// Parametrised input PIO with sticky edge capture and masked irq.
// Registers: DATA (RO), reserved, IRQ_MASK (RW), EDGE_CAP (W1C).
module nios_pio_edge_in
    import nios_pio_pkg::*;
#(
    parameter int               WIDTH       = 8,
    parameter int               SYNC_STAGES = 2,
    parameter int               EDGE_TYPE   = EDGE_RISE,
    parameter logic [WIDTH-1:0] RESET_MASK  = '0
) (
    input  logic                 clk,
    input  logic                 reset,
    nios_pio_edge_in_if.slave    bus,
    input  logic [WIDTH-1:0]     in_port,
    output logic                 irq
);

    generate
        if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
            $error("WIDTH must be 1..32");
        end
        if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
            $error("SYNC_STAGES must be 2..4");
        end
        if (EDGE_TYPE < EDGE_RISE || EDGE_TYPE > EDGE_ANY) begin : g_bad_edge
            $error("EDGE_TYPE must be 0..2");
        end
    endgenerate

    logic [WIDTH-1:0] sync;
    logic [WIDTH-1:0] edge_vec;
    logic [WIDTH-1:0] mask_q;
    logic [WIDTH-1:0] cap_q;
    logic [WIDTH-1:0] clr;
    logic [31:0]      rd_next;
    logic [31:0]      rd_q;
    logic             wr;
    logic             wr_mask;
    logic             wr_edge;
    logic             unused_wd;

    pio_sync_edge #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES),
        .EDGE_TYPE   (EDGE_TYPE)
    ) u_sync (
        .clk      (clk),
        .reset    (reset),
        .in_port  (in_port),
        .sync     (sync),
        .edge_vec (edge_vec)
    );

    assign wr      = bus.chipselect & ~bus.write_n;
    assign wr_mask = wr & (bus.address == ADDR_MASK);
    assign wr_edge = wr & (bus.address == ADDR_EDGE);
    assign clr     = wr_edge ? bus.writedata[WIDTH-1:0] : '0;

    assign unused_wd = ^bus.writedata;

    // Read mux; address alone selects, chipselect is ignored.
    always_comb begin
        rd_next = '0;
        unique case (1'b1)
            (bus.address == ADDR_DATA): rd_next[WIDTH-1:0] = sync;
            (bus.address == ADDR_RSVD): rd_next = '0;
            (bus.address == ADDR_MASK): rd_next[WIDTH-1:0] = mask_q;
            (bus.address == ADDR_EDGE): rd_next[WIDTH-1:0] = cap_q;
            default:                    rd_next = '0;
        endcase
    end

    // Mask register written directly from the bus.
    always_ff @(posedge clk) begin
        if (reset) begin
            mask_q <= RESET_MASK;
        end else if (wr_mask) begin
            mask_q <= bus.writedata[WIDTH-1:0];
        end
    end

    // Sticky capture: a fresh edge overrides a same-cycle clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            cap_q <= '0;
        end else begin
            cap_q <= (cap_q & ~clr) | edge_vec;
        end
    end

    // Readdata is registered every cycle for one-clock read latency.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_q <= '0;
        end else begin
            rd_q <= rd_next;
        end
    end

    assign bus.readdata = rd_q;
    assign irq          = |(cap_q & mask_q);

endmodule

// File: tb/tb_nios_pio_edge_in.sv
// Bench for nios_pio_edge_in: rise, fall and any-edge instances.
// Directed scenarios plus random traffic against a history-based model.
module tb_nios_pio_edge_in;

    localparam int N = 2;
    localparam logic [7:0] RM1 = 8'hA5;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  in_port = 8'hFF;
    logic [1:0]  address = 2'd0;
    logic        cs = 1'b0;
    logic        wn = 1'b1;
    logic [31:0] wdata = 32'h0;
    logic [31:0] rd [3];
    logic [2:0]  irq_v;

    int n_chk = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    nios_pio_edge_in_if bus0 ();
    nios_pio_edge_in_if bus1 ();
    nios_pio_edge_in_if bus2 ();

    assign bus0.address = address;
    assign bus0.chipselect = cs;
    assign bus0.write_n = wn;
    assign bus0.writedata = wdata;
    assign bus1.address = address;
    assign bus1.chipselect = cs;
    assign bus1.write_n = wn;
    assign bus1.writedata = wdata;
    assign bus2.address = address;
    assign bus2.chipselect = cs;
    assign bus2.write_n = wn;
    assign bus2.writedata = wdata;
    assign rd[0] = bus0.readdata;
    assign rd[1] = bus1.readdata;
    assign rd[2] = bus2.readdata;

    nios_pio_edge_in #(.WIDTH(8), .SYNC_STAGES(N), .EDGE_TYPE(0),
                       .RESET_MASK(8'h00)) dut0 (
        .clk(clk), .reset(reset), .bus(bus0),
        .in_port(in_port), .irq(irq_v[0]));

    nios_pio_edge_in #(.WIDTH(8), .SYNC_STAGES(N), .EDGE_TYPE(1),
                       .RESET_MASK(RM1)) dut1 (
        .clk(clk), .reset(reset), .bus(bus1),
        .in_port(in_port), .irq(irq_v[1]));

    nios_pio_edge_in #(.WIDTH(8), .SYNC_STAGES(N), .EDGE_TYPE(2),
                       .RESET_MASK(8'h00)) dut2 (
        .clk(clk), .reset(reset), .bus(bus2),
        .in_port(in_port), .irq(irq_v[2]));

    // ---------------- reference model ----------------
    int         cyc = 0;
    int         last_rst = 0;
    logic [7:0] in_h [0:8191];
    bit         rst_h [0:8191];
    logic [7:0] m_cap [3];
    logic [7:0] m_mask [3];
    logic [31:0] m_rd [3];

    function automatic logic [7:0] rm(input int m);
        return (m == 1) ? RM1 : 8'h00;
    endfunction

    // Synchronized value after edge j: input seen N-1 edges earlier,
    // or zero if a reset edge lies inside that window.
    function automatic logic [7:0] sync_after(input int j);
        if (j - N + 1 < 0) return 8'h00;
        for (int i = j - N + 1; i <= j; i++)
            if (rst_h[i]) return 8'h00;
        return in_h[j - N + 1];
    endfunction

    function automatic logic [7:0] prev_after(input int j);
        if (j < 0 || rst_h[j]) return 8'h00;
        return sync_after(j - 1);
    endfunction

    always @(posedge clk) begin : model
        logic [7:0] s, p, e;
        bit en;
        in_h[cyc] = in_port;
        rst_h[cyc] = reset;
        if (reset) begin
            last_rst = cyc;
            for (int m = 0; m < 3; m++) begin
                m_cap[m] = 8'h00;
                m_mask[m] = rm(m);
                m_rd[m] = 32'h0;
            end
        end else begin
            s = sync_after(cyc - 1);
            p = prev_after(cyc - 1);
            en = (cyc - last_rst) >= N + 2;
            for (int m = 0; m < 3; m++) begin
                case (address)
                    2'd0: m_rd[m] = {24'h0, s};
                    2'd1: m_rd[m] = 32'h0;
                    2'd2: m_rd[m] = {24'h0, m_mask[m]};
                    default: m_rd[m] = {24'h0, m_cap[m]};
                endcase
                if (m == 0) e = s & ~p;
                else if (m == 1) e = ~s & p;
                else e = s ^ p;
                if (!en) e = 8'h00;
                if (cs && !wn && address == 2'd2) m_mask[m] = wdata[7:0];
                if (cs && !wn && address == 2'd3) m_cap[m] &= ~wdata[7:0];
                m_cap[m] |= e;
            end
        end
        cyc++;
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        address = a;
        cs = 1'b1;
        wn = 1'b0;
        wdata = d;
        tick();
        cs = 1'b0;
        wn = 1'b1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset;
        tick(3);
        for (int m = 0; m < 3; m++) begin
            n_chk++;
            if (rd[m] !== 32'h0 || irq_v[m] !== 1'b0)
                $display("FAIL reset_state[%0d]: rd=%h irq=%b want 0/0",
                         m, rd[m], irq_v[m]);
            else n_pass++;
        end
        reset = 1'b0;
        address = 2'd0;
        tick(5);
        for (int m = 0; m < 3; m++) begin
            n_chk++;
            if (rd[m] !== 32'h000000FF)
                $display("FAIL reset_data[%0d]: got %h want 000000ff", m, rd[m]);
            else n_pass++;
        end
        address = 2'd3;
        tick();
        for (int m = 0; m < 3; m++) begin
            n_chk++;
            if (rd[m] !== 32'h0 || irq_v[m] !== 1'b0)
                $display("FAIL reset_nospur[%0d]: cap=%h irq=%b want 0/0",
                         m, rd[m], irq_v[m]);
            else n_pass++;
        end
    endtask

    task automatic test_rise;
        in_port = 8'h00;
        tick(4);
        wr(2'd2, 32'h1);
        wr(2'd3, 32'hFF);
        in_port = 8'h01;
        tick();
        n_chk++;
        if (irq_v[0] !== 1'b0) $display("FAIL rise_k: irq=%b want 0", irq_v[0]);
        else n_pass++;
        tick();
        n_chk++;
        if (irq_v[0] !== 1'b0) $display("FAIL rise_k1: irq=%b want 0", irq_v[0]);
        else n_pass++;
        tick();
        n_chk++;
        if (irq_v[0] !== 1'b1) $display("FAIL rise_k2: irq=%b want 1", irq_v[0]);
        else n_pass++;
        tick();
        n_chk++;
        if (rd[0] !== 32'h1) $display("FAIL rise_read: got %h want 00000001", rd[0]);
        else n_pass++;
    endtask

    task automatic test_collide;
        in_port = 8'h00;
        tick(3);
        in_port = 8'h01;
        tick(2);
        wr(2'd3, 32'h1);
        n_chk++;
        if (irq_v[0] !== 1'b1) $display("FAIL collide_edge_wins: irq=%b want 1", irq_v[0]);
        else n_pass++;
        tick();
        wr(2'd3, 32'h1);
        n_chk++;
        if (irq_v[0] !== 1'b0) $display("FAIL collide_clear_irq: irq=%b want 0", irq_v[0]);
        else n_pass++;
        tick();
        n_chk++;
        if (rd[0] !== 32'h0) $display("FAIL collide_clear_cap: got %h want 0", rd[0]);
        else n_pass++;
    endtask

    task automatic test_any;
        wr(2'd2, 32'h0);
        wr(2'd3, 32'hFF);
        in_port = 8'h09;
        tick(3);
        in_port = 8'h01;
        tick(3);
        tick();
        n_chk++;
        if (rd[2] !== 32'h08 || irq_v[2] !== 1'b0)
            $display("FAIL any_toggle: cap=%h irq=%b want 00000008/0", rd[2], irq_v[2]);
        else n_pass++;
        wr(2'd2, 32'h08);
        n_chk++;
        if (irq_v[2] !== 1'b1) $display("FAIL any_mask_irq: irq=%b want 1", irq_v[2]);
        else n_pass++;
    endtask

    task automatic test_reg_map;
        wr(2'd1, 32'hFFFFFFFF);
        wr(2'd2, 32'hFFFFFFFF);
        address = 2'd1;
        tick();
        for (int m = 0; m < 3; m++) begin
            n_chk++;
            if (rd[m] !== 32'h0) $display("FAIL rsvd_read[%0d]: got %h want 0", m, rd[m]);
            else n_pass++;
        end
        address = 2'd2;
        tick();
        for (int m = 0; m < 3; m++) begin
            n_chk++;
            if (rd[m] !== 32'h000000FF)
                $display("FAIL mask_read[%0d]: got %h want 000000ff", m, rd[m]);
            else n_pass++;
        end
    endtask

    task automatic test_midreset;
        wr(2'd3, 32'hFF);
        in_port = 8'h54;
        tick(3);
        address = 2'd3;
        tick();
        n_chk++;
        if (rd[2] !== 32'h55 || irq_v[2] !== 1'b1)
            $display("FAIL mid_setup: cap=%h irq=%b want 00000055/1", rd[2], irq_v[2]);
        else n_pass++;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int m = 0; m < 3; m++) begin
            n_chk++;
            if (rd[m] !== 32'h0 || irq_v[m] !== 1'b0)
                $display("FAIL mid_reset[%0d]: rd=%h irq=%b want 0/0", m, rd[m], irq_v[m]);
            else n_pass++;
        end
        address = 2'd2;
        tick();
        for (int m = 0; m < 3; m++) begin
            n_chk++;
            if (rd[m] !== {24'h0, rm(m)})
                $display("FAIL mid_mask[%0d]: got %h want %h", m, rd[m], {24'h0, rm(m)});
            else n_pass++;
        end
        address = 2'd3;
        for (int t = 0; t < N + 3; t++) begin
            tick();
            for (int m = 0; m < 3; m++) begin
                n_chk++;
                if (rd[m] !== 32'h0 || irq_v[m] !== 1'b0)
                    $display("FAIL mid_prime[%0d] t%0d: cap=%h irq=%b want 0/0",
                             m, t, rd[m], irq_v[m]);
                else n_pass++;
            end
        end
    endtask

    task automatic test_random;
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 5) == 0) in_port = 8'($urandom);
            reset = ($urandom_range(0, 79) == 0);
            address = 2'($urandom);
            cs = 1'($urandom);
            wn = ($urandom_range(0, 2) != 0);
            wdata = $urandom;
            tick();
            for (int m = 0; m < 3; m++) begin
                n_chk++;
                if (rd[m] !== m_rd[m])
                    $display("FAIL rand_rd[%0d] c%0d: got %h want %h", m, c, rd[m], m_rd[m]);
                else n_pass++;
                n_chk++;
                if (irq_v[m] !== |(m_cap[m] & m_mask[m]))
                    $display("FAIL rand_irq[%0d] c%0d: got %b want %b",
                             m, c, irq_v[m], |(m_cap[m] & m_mask[m]));
                else n_pass++;
            end
        end
        reset = 1'b0;
        cs = 1'b0;
        wn = 1'b1;
    endtask

    initial begin
        test_reset();
        test_rise();
        test_collide();
        test_any();
        test_reg_map();
        test_midreset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/nios_pio_edge_in.md
Name: nios_pio_edge_in

Overview:
- Parametrised successor to the single-bit Avalon-MM input PIO slave in the nios_system.
- Samples a WIDTH-bit asynchronous input bus through a synchronizer and exposes the synchronized value to the Nios II on one Avalon-MM slave.
- Adds per-bit edge capture, a write-1-to-clear capture register, a per-bit interrupt mask and a level-high irq output.
- Intended for keypad, switch and UART-status style inputs that need interrupt-driven handling instead of polling.

Parameters:
WIDTH, 8, number of input bits (1..32)
SYNC_STAGES, 2, synchronizer flops per bit (2..4)
EDGE_TYPE, 0, capture mode: 0 rising, 1 falling, 2 any edge
RESET_MASK, 0, reset value of interrupt mask register (WIDTH bits)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
address  input  2  Avalon word address
chipselect  input  1  slave select
write_n  input  1  active-low write strobe
writedata  input  32  write data
in_port  input  WIDTH  asynchronous external inputs
readdata  output  32  registered read data
irq  output  1  interrupt request, level, active-high

Behaviour:
- Reset: the design has one clock. Reset is synchronous and active-high on port reset.
  - Reset clears all synchronizer flops, the prev register, the edge capture register, readdata (0) and irq (0).
  - The mask register resets to RESET_MASK.
  - The prime counter resets to 0.
- Register map (32-bit words, bits above WIDTH read 0 and ignore writes):
  - addr 0: DATA, RO. Returns the synchronized input value.
  - addr 1: reserved. Reads 0, writes ignored.
  - addr 2: IRQ_MASK, RW.
  - addr 3: EDGE_CAP, read / write-1-to-clear.
- Read path:
  - readdata is registered every clock from the mux selected by address. It does not depend on chipselect.
  - Read latency is 1 clock: the address presented at edge k produces readdata after edge k.
- Write path:
  - A write occurs when chipselect=1 and write_n=0 at a clock edge.
  - IRQ_MASK takes writedata[WIDTH-1:0] at that edge.
  - For EDGE_CAP, bits set in writedata clear the corresponding capture bits at that edge.
- Synchronizer and edge detection:
  - Stages s[1..SYNC_STAGES]. The sync output is s[SYNC_STAGES]. The prev register follows the sync output one clock later.
  - Edge term per bit:
    - rising: sync & ~prev
    - falling: ~sync & prev
    - any: sync ^ prev
- Latency, SYNC_STAGES=2: an in_port change set up before edge k appears on DATA internally after edge k+1. The capture bit sets at edge k+2, and irq rises after edge k+2.
- Prime counter:
  - Counts from 0 to SYNC_STAGES+1 after reset release, then saturates.
  - Edge detection is gated off until the count reaches SYNC_STAGES+1. Inputs held constant through reset therefore never produce a spurious capture.
- Capture is sticky: a bit stays set until cleared by software or reset.
- A simultaneous detected edge and write-1-clear on the same bit leaves the bit set (the edge wins).
- irq = OR over bits of (EDGE_CAP & IRQ_MASK). It is combinational from the registers, with no extra cycle.
- A mask write that enables an already-set capture bit raises irq after that edge.
- Reset asserted mid-operation behaves the same as power-up reset, including re-priming.

Decomposition:
- Package nios_pio_pkg holds:
  - address constants ADDR_DATA=0, ADDR_RSVD=1, ADDR_MASK=2, ADDR_EDGE=3
  - edge mode constants EDGE_RISE=0, EDGE_FALL=1, EDGE_ANY=2
- Sub-module pio_sync_edge contains the WIDTH-bit synchronizer, the prev register, the prime counter and the edge term generation. Its output is the sync value plus the edge vector.
- The top level holds the registers, the read mux and irq.

Test Plan:
- Reset with in_port=8'hFF held, then release and read addr 0 and addr 3. Required: DATA=32'h000000FF, EDGE_CAP=0, irq=0 (no spurious edges).
- EDGE_TYPE=0: write IRQ_MASK=8'h01, drive in_port bit0 0->1 before edge k. Required: EDGE_CAP=8'h01 at edge k+2, irq=1 from the same cycle, readback of addr 3 = 32'h1.
- Write EDGE_CAP=8'h01 on the same edge that a new rising edge on bit0 is detected. Required: the bit stays 1 and irq stays 1. A clear on a later idle cycle gives EDGE_CAP=0 and irq=0.
- EDGE_TYPE=2, mask=0: toggle bit3 high then low. Required: EDGE_CAP=8'h08 and irq=0. A subsequent IRQ_MASK=8'h08 write raises irq after that write edge.
- Write 32'hFFFFFFFF to addr 1 and to IRQ_MASK with WIDTH=8. Required: addr 1 reads 0, IRQ_MASK reads 32'h000000FF, each exactly 1 clock after the address is presented.
- Assert reset for 1 cycle while EDGE_CAP=8'h55 and mask=8'hFF. Required: EDGE_CAP=0, mask=RESET_MASK and irq=0 on the next cycle, and no capture during the SYNC_STAGES+1 priming cycles.
